// File: rtl/comparador_objetivo.sv
// comparador_objetivo: search controller between the hash core and the nonce
// generator. Compares each hash against a latched difficulty target, counts
// attempts, and reports the winning (or last tried) nonce and hash.
module comparador_objetivo #(
  parameter int unsigned HASH_W       = 32,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned MAX_INTENTOS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [HASH_W-1:0] target,
  input  logic [HASH_W-1:0] hash_in,
  input  logic [31:0]       nonce_in,
  input  logic              hash_valid,
  output logic              valid,
  output logic              fin,
  output logic              exito,
  output logic              timeout,
  output logic [31:0]       nonce_out,
  output logic [HASH_W-1:0] hash_out,
  output logic [CNT_W-1:0]  intentos
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INTENTOS);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    CHECK,
    DONE
  } state_t;

  state_t            state;
  logic [HASH_W-1:0] target_q;

  // Search FSM; valid is 0 only while waiting for a result in SEARCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      valid     <= 1'b1;
      fin       <= 1'b0;
      exito     <= 1'b0;
      timeout   <= 1'b0;
      intentos  <= '0;
      nonce_out <= '0;
      hash_out  <= '0;
      target_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            target_q <= target;
            intentos <= '0;
            valid    <= 1'b0;
            state    <= SEARCH;
          end
        end
        SEARCH: begin
          if (hash_valid) begin
            hash_out  <= hash_in;
            nonce_out <= nonce_in;
            intentos  <= intentos + CNT_W'(1);
            valid     <= 1'b1;
            state     <= CHECK;
          end
        end
        CHECK: begin
          // Success takes priority so a win on the last attempt is not a timeout.
          if (hash_out < target_q) begin
            exito <= 1'b1;
            fin   <= 1'b1;
            state <= DONE;
          end else if (intentos == MAX_CNT) begin
            timeout <= 1'b1;
            fin     <= 1'b1;
            state   <= DONE;
          end else begin
            valid <= 1'b0;
            state <= SEARCH;
          end
        end
        DONE: begin
          if (start) begin
            fin      <= 1'b0;
            exito    <= 1'b0;
            timeout  <= 1'b0;
            intentos <= '0;
            target_q <= target;
            valid    <= 1'b0;
            state    <= SEARCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comparador_objetivo.sv
// Self-checking bench for comparador_objetivo: directed cases plus randomized
// searches checked against an outcome model of the search rules.
module tb_comparador_objetivo;

  localparam int unsigned HASH_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned MAX    = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [HASH_W-1:0] target = '0;
  logic [HASH_W-1:0] hash_in = '0;
  logic [31:0]       nonce_in = '0;
  logic              hash_valid = 1'b0;
  logic              valid, fin, exito, timeout;
  logic [31:0]       nonce_out;
  logic [HASH_W-1:0] hash_out;
  logic [CNT_W-1:0]  intentos;

  int checks = 0;
  int errors = 0;

  // Reference model: outcome of the current search in plain terms.
  bit          m_active;
  bit          m_exito;
  bit          m_to;
  int unsigned m_cnt;
  logic [31:0] m_tgt;
  logic [31:0] m_hash;
  logic [31:0] m_nonce;

  comparador_objetivo #(
    .HASH_W(HASH_W), .CNT_W(CNT_W), .MAX_INTENTOS(MAX)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .target(target),
    .hash_in(hash_in), .nonce_in(nonce_in), .hash_valid(hash_valid),
    .valid(valid), .fin(fin), .exito(exito), .timeout(timeout),
    .nonce_out(nonce_out), .hash_out(hash_out), .intentos(intentos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".valid"},     32'(valid),     m_active ? 32'd0 : 32'd1);
    chk({ctx, ".fin"},       32'(fin),       32'(m_exito | m_to));
    chk({ctx, ".exito"},     32'(exito),     32'(m_exito));
    chk({ctx, ".timeout"},   32'(timeout),   32'(m_to));
    chk({ctx, ".intentos"},  32'(intentos),  m_cnt);
    chk({ctx, ".nonce_out"}, nonce_out,      m_nonce);
    chk({ctx, ".hash_out"},  hash_out,       m_hash);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_active = 0; m_exito = 0; m_to = 0; m_cnt = 0;
    m_tgt = '0; m_hash = '0; m_nonce = '0;
    check_all("reset");
  endtask

  // Pulse start; the model honours it only when no search is in progress.
  task automatic do_start(input logic [31:0] t);
    target = t;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    if (!m_active) begin
      m_tgt = t; m_cnt = 0; m_exito = 0; m_to = 0; m_active = 1;
    end
    check_all("start");
  endtask

  // Deliver one result; dirty keeps hash_valid high through the compare cycle.
  task automatic feed(input logic [31:0] h, input logic [31:0] n, input bit dirty);
    hash_in = h; nonce_in = n; hash_valid = 1'b1;
    tick();
    m_cnt++; m_hash = h; m_nonce = n;
    chk("feed.valid_hold", 32'(valid), 32'd1);
    chk("feed.intentos", 32'(intentos), m_cnt);
    chk("feed.fin_early", 32'(fin), 32'd0);
    if (dirty) begin
      hash_in = ~h; nonce_in = ~n;
    end else begin
      hash_valid = 1'b0;
    end
    tick();
    hash_valid = 1'b0;
    if (h < m_tgt) begin
      m_exito = 1; m_active = 0;
    end else if (m_cnt == MAX) begin
      m_to = 1; m_active = 0;
    end
    check_all("feed");
  endtask

  // Idle cycles; hash_valid may be held only when no search is running.
  task automatic idle(input int k, input bit hv);
    hash_valid = hv && !m_active;
    hash_in = $urandom; nonce_in = $urandom;
    for (int i = 0; i < k; i++) tick();
    hash_valid = 1'b0;
    check_all("idle");
  endtask

  function automatic logic [31:0] pick_hash(input logic [31:0] t);
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return t - 32'd1;
      2: return t;
      3: return t + 32'd1;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Reset state and hash_valid ignored in IDLE
    do_reset();
    idle(3, 1'b1);

    // Success on the 4th (last permitted) attempt reports exito
    do_start(32'h0010_0000);
    feed(32'hFFFF_0000, 32'h0000_0001, 1'b0);
    feed(32'h2000_0000, 32'h0000_0002, 1'b0);
    feed(32'h0010_0001, 32'h0000_0003, 1'b0);
    feed(32'h000F_FFFF, 32'h80a9_d9e7, 1'b0);
    chk("t1.exito", 32'(exito), 32'd1);
    chk("t1.nonce", nonce_out, 32'h80a9_d9e7);
    // DONE holds against hash_valid and target changes
    target = 32'h0;
    idle(4, 1'b1);

    // Restart from DONE; hash==target is a failure
    do_start(32'h0000_1000);
    feed(32'h0000_1000, 32'h0000_0010, 1'b0);
    chk("t2.valid_advance", 32'(valid), 32'd0);
    idle(2, 1'b0);
    feed(32'h0000_0FFF, 32'h0000_0011, 1'b0);

    // target=0 can never succeed: timeout at MAX
    do_start(32'h0);
    feed(32'h0000_0000, 32'h0000_0100, 1'b0);
    feed(32'h0000_0001, 32'h0000_0101, 1'b0);
    feed(32'hFFFF_FFFF, 32'h0000_0102, 1'b0);
    feed(32'h0000_0000, 32'hCAFE_0004, 1'b0);
    chk("t3.timeout", 32'(timeout), 32'd1);
    chk("t3.nonce", nonce_out, 32'hCAFE_0004);

    // Reset mid-search
    do_start(32'h0000_0010);
    feed(32'h0000_0100, 32'h1, 1'b0);
    feed(32'h0000_0100, 32'h2, 1'b0);
    feed(32'h0000_0100, 32'h3, 1'b0);
    do_reset();

    // start ignored in SEARCH; hash_valid ignored in CHECK; target edits ignored
    do_start(32'h0000_0010);
    do_start(32'hFFFF_FFFF);
    target = 32'hFFFF_FFFF;
    feed(32'h0000_0020, 32'h0000_0AAA, 1'b1);
    feed(32'h0000_000F, 32'h0000_0BBB, 1'b1);

    // Randomized searches against the model
    for (int s = 0; s < 60; s++) begin
      do_start(pick_target());
      for (int g = 0; g < 8 && m_active; g++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1'b0);
        if ($urandom_range(0, 5) == 0) target = $urandom;
        if ($urandom_range(0, 7) == 0) do_start($urandom);
        feed(pick_hash(m_tgt), $urandom, 1'($urandom_range(0, 1)));
      end
      chk("rand.finished", 32'(fin), 32'd1);
      if ($urandom_range(0, 9) == 0) do_reset();
      else idle($urandom_range(1, 2), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
